// File: rtl/and_tree_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : and_tree_pipe
//  Brief    : WIDTH-input AND reduction built from FANIN-input nodes, with
//             optional per-level pipeline registers, valid/stall handshake
//             and a sticky all-ones match flag.
//  Revision : 1.0 - initial release
// ============================================================================
module and_tree_pipe #(
    parameter int WIDTH  = 11,
    parameter int FANIN  = 6,
    parameter int PIPE   = 1,
    parameter int INVERT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             clr,
    output logic             z,
    output logic             z_valid,
    output logic             sticky
);

    // Guarded fan-in keeps the constant functions terminating even when the
    // parameter check below is about to reject the configuration.
    localparam int c_FI = (FANIN < 2) ? 2 : FANIN;

    // Number of nodes present at a given tree level (level 0 = the inputs)
    function automatic int f_nodes(input int lvl);
        int n;
        n = WIDTH;
        for (int i = 0; i < lvl; i++) begin
            n = (n + c_FI - 1) / c_FI;
        end
        return n;
    endfunction

    // Levels needed until a single node remains; at least one level always
    function automatic int f_levels();
        int n;
        int l;
        n = (WIDTH + c_FI - 1) / c_FI;
        l = 1;
        while (n > 1) begin
            n = (n + c_FI - 1) / c_FI;
            l++;
        end
        return l;
    endfunction

    localparam int c_LEVELS = f_levels();

    if (WIDTH < 2 || WIDTH > 64 || FANIN < 2 || FANIN > 8 ||
        (PIPE != 0 && PIPE != 1) || (INVERT != 0 && INVERT != 1)) begin : g_bad_param
        $error("and_tree_pipe: WIDTH, FANIN, PIPE or INVERT out of range");
    end

    for (genvar k = 1; k <= c_LEVELS; k++) begin : g_lvl
        localparam int c_NIN  = f_nodes(k - 1);
        localparam int c_NOUT = f_nodes(k);

        logic [c_NIN-1:0]  w_src;
        logic              w_vsrc;
        logic [c_NOUT-1:0] w_node;
        logic [c_NOUT-1:0] w_out;
        logic              w_vout;

        if (k == 1) begin : g_head
            assign w_src  = a;
            assign w_vsrc = in_valid;
        end else begin : g_link
            assign w_src  = g_lvl[k-1].w_out;
            assign w_vsrc = g_lvl[k-1].w_vout;
        end

        // The last node of a level may have fewer children; absent ones act as 1
        for (genvar j = 0; j < c_NOUT; j++) begin : g_node
            localparam int c_LO  = j * c_FI;
            localparam int c_CNT = ((c_NIN - c_LO) < c_FI) ? (c_NIN - c_LO) : c_FI;
            assign w_node[j] = &w_src[c_LO +: c_CNT];
        end

        if (PIPE != 0) begin : g_reg
            logic [c_NOUT-1:0] data_q;
            logic [c_NOUT-1:0] data_d;
            logic              valid_q;
            logic              valid_d;

            // Freeze the stage while stalled, otherwise take this level's nodes
            always_comb begin
                data_d  = stall ? data_q  : w_node;
                valid_d = stall ? valid_q : w_vsrc;
            end

            // Stage register; reset discards whatever is in flight
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign w_out  = data_q;
            assign w_vout = valid_q;
        end else begin : g_comb
            assign w_out  = w_node;
            assign w_vout = w_vsrc;
        end
    end

    logic w_and;
    logic w_stall_hold;
    logic sticky_q;
    logic sticky_d;

    assign w_and        = g_lvl[c_LEVELS].w_out[0];
    assign z_valid      = g_lvl[c_LEVELS].w_vout;
    assign z            = (INVERT != 0) ? ~w_and : w_and;
    // A held result under stall must not be re-evaluated into the flag
    assign w_stall_hold = (PIPE != 0) && stall;

    // Sticky next state: clear wins over a coincident setting result
    always_comb begin
        sticky_d = clr ? 1'b0 : (sticky_q | (z_valid & w_and & ~w_stall_hold));
    end

    // Sticky match register
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_and_tree_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_and_tree_pipe
//  Brief    : Scoreboard bench for and_tree_pipe (pipelined 11-bit instance
//             plus a combinational inverted 5-bit instance).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_and_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Pipelined instance: WIDTH=11, FANIN=6, PIPE=1 -> two levels
    logic        reset;
    logic [10:0] a;
    logic        in_valid;
    logic        stall;
    logic        clr;
    logic        z;
    logic        z_valid;
    logic        sticky;

    // Combinational instance: WIDTH=5, PIPE=0, INVERT=1
    logic [4:0]  p0_a;
    logic        p0_v;
    logic        p0_stall;
    logic        p0_clr;
    logic        p0_z;
    logic        p0_zv;
    logic        p0_sticky;

    and_tree_pipe #(.WIDTH(11), .FANIN(6), .PIPE(1), .INVERT(0)) u_dut (
        .clk(clk), .reset(reset), .a(a), .in_valid(in_valid), .stall(stall),
        .clr(clr), .z(z), .z_valid(z_valid), .sticky(sticky)
    );

    and_tree_pipe #(.WIDTH(5), .FANIN(6), .PIPE(0), .INVERT(1)) u_dut_comb (
        .clk(clk), .reset(reset), .a(p0_a), .in_valid(p0_v), .stall(p0_stall),
        .clr(p0_clr), .z(p0_z), .z_valid(p0_zv), .sticky(p0_sticky)
    );

    localparam int L = 2;   // ceil(11/6)=2 nodes, then 1 node

    typedef struct {
        bit andv;
        int due;
    } item_t;

    item_t q[$];
    int    adv        = 0;   // count of edges on which the pipeline advanced
    int    edge_kind  = 0;   // 0 reset edge, 1 advancing edge, 2 stalled edge
    bit    pres_valid = 1'b0;
    bit    pres_and   = 1'b0;
    bit    mdl_sticky = 1'b0;
    bit    run_mon    = 1'b0;
    int    n_checks   = 0;
    int    n_err      = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted operands enter the scoreboard with the
    // advance count at which their result must appear.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            mdl_sticky = 1'b0;
            edge_kind  = 0;
        end else begin
            if (clr)
                mdl_sticky = 1'b0;
            else if (pres_valid && pres_and && !stall)
                mdl_sticky = 1'b1;
            if (stall) begin
                edge_kind = 2;
            end else begin
                adv++;
                edge_kind = 1;
                if (in_valid)
                    q.push_back('{andv: (&a), due: adv + L - 1});
            end
        end
    end

    // Monitor: pops the scoreboard when a result is due, compares outputs
    always @(negedge clk) begin
        if (run_mon) begin
            if (edge_kind == 0) begin
                pres_valid = 1'b0;
                chk("reset_z", z, 1'b0);
            end else if (edge_kind == 1) begin
                if (q.size() > 0 && q[0].due == adv) begin
                    pres_and   = q[0].andv;
                    pres_valid = 1'b1;
                    void'(q.pop_front());
                end else begin
                    pres_valid = 1'b0;
                end
            end
            chk("z_valid", z_valid, pres_valid);
            if (pres_valid)
                chk("z", z, pres_and);
            chk("sticky", sticky, mdl_sticky);
        end
    end

    task automatic drive(input logic [10:0] av, input logic v, input logic s,
                         input logic c, input logic r);
        @(posedge clk);
        #2;
        a        = av;
        in_valid = v;
        stall    = s;
        clr      = c;
        reset    = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; a = '0; in_valid = 1'b0; stall = 1'b0; clr = 1'b0;
        p0_a = '0; p0_v = 1'b0; p0_stall = 1'b0; p0_clr = 1'b0;

        drive(11'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_mon = 1'b1;
        idle(2);

        // Single all-ones item
        drive(11'h7FF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Back-to-back all-ones then one zero bit
        drive(11'h7FF, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(11'h3FF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        drive(11'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // One item in flight, stalled for three cycles
        drive(11'h7FF, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(11'h7FF, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);

        // Reset with items in flight
        drive(11'h7FF, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(11'h7FF, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(4);

        // clr coinciding with an all-ones result while sticky is set
        drive(11'h7FF, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(11'h7FF, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(11'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(11'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Walking single zero across every input bit
        for (int i = 0; i < 11; i++) begin
            logic [10:0] w;
            w    = 11'h7FF;
            w[i] = 1'b0;
            drive(w, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle(4);

        // Randomised traffic with stalls, clears and rare resets
        for (int n = 0; n < 400; n++) begin
            logic [10:0] av;
            av = ($urandom_range(0, 1) == 1) ? 11'h7FF : 11'($urandom);
            drive(av, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end
        idle(6);
        chk("drain_empty", q.size() == 0, 1'b1);

        // Combinational inverted instance, all within one clock period
        @(posedge clk);
        #1;
        chk("p0_sticky_init", p0_sticky, 1'b0);
        p0_a = 5'h1F; p0_v = 1'b1; #1;
        chk("p0_z_ones", p0_z, 1'b0);
        chk("p0_zv", p0_zv, 1'b1);
        p0_a = 5'h1E; #1;
        chk("p0_z_1E", p0_z, 1'b1);
        for (int i = 0; i < 5; i++) begin
            logic [4:0] w;
            w    = 5'h1F;
            w[i] = 1'b0;
            p0_a = w;
            #1;
            chk("p0_walk", p0_z, 1'b1);
        end
        p0_v = 1'b0; p0_a = 5'h00;
        #1;
        chk("p0_zv_low", p0_zv, 1'b0);

        // Sticky in combinational mode sets even with stall high; clr wins
        p0_stall = 1'b1; p0_a = 5'h1F; p0_v = 1'b1;
        @(posedge clk);
        #2;
        chk("p0_sticky_set", p0_sticky, 1'b1);
        p0_clr = 1'b1;
        @(posedge clk);
        #2;
        chk("p0_sticky_clr", p0_sticky, 1'b0);
        p0_clr = 1'b0; p0_v = 1'b0; p0_stall = 1'b0;

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
